// File: rtl/sgm_path_aggr_pkg.sv
// Shared definitions for the SGM path-cost aggregator.
package sgm_path_aggr_pkg;

    localparam int SGM_DISP    = 96;
    localparam int SGM_CW      = 9;
    localparam int SGM_MAX_COL = 400;
    localparam int SGM_RC_W    = 10;

    // Path direction for the current frame
    typedef enum logic {
        DIR_HORZ = 1'b0,
        DIR_VERT = 1'b1
    } dir_e;

endpackage

// File: rtl/sgm_path_aggr_min_tree.sv
// Combinational minimum of N packed W-bit values, built as a balanced binary tree.
module sgm_path_aggr_min_tree #(
    parameter int N = 96,
    parameter int W = 9
) (
    input  logic [N*W-1:0] vals,
    output logic [W-1:0]   min_val
);

    if (N == 1) begin : g_leaf
        assign min_val = vals;
    end else begin : g_split
        localparam int NL = N / 2;
        localparam int NR = N - NL;
        logic [W-1:0] min_l;
        logic [W-1:0] min_r;

        sgm_path_aggr_min_tree #(.N(NL), .W(W)) u_lo (
            .vals    (vals[NL*W-1:0]),
            .min_val (min_l)
        );

        sgm_path_aggr_min_tree #(.N(NR), .W(W)) u_hi (
            .vals    (vals[N*W-1:NL*W]),
            .min_val (min_r)
        );

        assign min_val = (min_l <= min_r) ? min_l : min_r;
    end

endmodule

// File: rtl/sgm_path_aggr.sv
// One-direction SGM path-cost aggregator, horizontal L->R or vertical T->B.
// Two-stage pipeline: stage A registers the pixel and reads the line buffer,
// stage B combines the cost with the predecessor L and registers the result.
module sgm_path_aggr
    import sgm_path_aggr_pkg::*;
#(
    parameter int DISP    = SGM_DISP,
    parameter int CW      = SGM_CW,
    parameter int MAX_COL = SGM_MAX_COL,
    parameter int RC_W    = SGM_RC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 dir,
    input  logic [CW-1:0]        p1,
    input  logic [CW-1:0]        p2,
    input  logic [DISP*CW-1:0]   cost_init,
    input  logic [RC_W-1:0]      row,
    input  logic [RC_W-1:0]      col,
    output logic [DISP*CW-1:0]   cost_aggr,
    output logic [CW-1:0]        cost_min,
    output logic [RC_W-1:0]      out_row,
    output logic [RC_W-1:0]      out_col,
    output logic                 valid
);

    localparam int IW = CW + 2;
    localparam int VW = DISP * CW;
    localparam int AW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    localparam logic [IW-1:0] SAT = IW'((1 << CW) - 1);

    dir_e              mode;
    dir_e              a_mode;
    logic              frame_start;
    logic              a_en;
    logic [VW-1:0]     a_cost;
    logic [RC_W-1:0]   a_row;
    logic [RC_W-1:0]   a_col;
    logic [CW-1:0]     a_p1;
    logic [CW-1:0]     a_p2;

    logic [VW-1:0]     lb_mem [MAX_COL];
    logic [VW-1:0]     lb_rd;
    logic              rd_ok;
    logic              wr_en;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     wr_addr;

    logic [VW-1:0]     lp_vec;
    logic [CW-1:0]     mp;
    logic              path_start;
    logic [VW-1:0]     l_vec;
    logic [CW-1:0]     l_min;
    logic [IW-1:0]     best;
    logic [IW-1:0]     cand;
    logic [IW-1:0]     sum;

    assign frame_start = en && (row == '0) && (col == '0);
    assign rd_ok       = col < RC_W'(MAX_COL);
    assign rd_addr     = AW'(col);
    assign wr_en       = a_en && (a_col < RC_W'(MAX_COL));
    assign wr_addr     = AW'(a_col);

    // Direction is latched only at the first pixel of a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode <= DIR_HORZ;
        else if (frame_start) mode <= dir_e'(dir);
    end

    // Stage A: capture the pixel together with the settings it must be processed with
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_en   <= 1'b0;
            a_mode <= DIR_HORZ;
            a_cost <= '0;
            a_row  <= '0;
            a_col  <= '0;
            a_p1   <= '0;
            a_p2   <= '0;
        end else begin
            a_en <= en;
            if (en) begin
                a_mode <= frame_start ? dir_e'(dir) : mode;
                a_cost <= cost_init;
                a_row  <= row;
                a_col  <= col;
                a_p1   <= p1;
                a_p2   <= (p2 > p1) ? p2 : p1;
            end
        end
    end

    // Line buffer: write L of stage B, read the row above for the incoming pixel; a same-column write wins
    always_ff @(posedge clk) begin
        if (wr_en) lb_mem[wr_addr] <= l_vec;
        if (en && rd_ok) lb_rd <= (wr_en && (wr_addr == rd_addr)) ? l_vec : lb_mem[rd_addr];
    end

    assign lp_vec     = (a_mode == DIR_VERT) ? lb_rd : cost_aggr;
    assign path_start = (a_mode == DIR_VERT) ? (a_row == '0) : (a_col == '0);

    sgm_path_aggr_min_tree #(.N(DISP), .W(CW)) u_min_prev (
        .vals    (lp_vec),
        .min_val (mp)
    );

    // Stage B arithmetic: best transition per disparity, normalised by Mp and saturated
    always_comb begin
        l_vec = '0;
        best  = '0;
        cand  = '0;
        sum   = '0;
        for (int d = 0; d < DISP; d++) begin
            best = {2'b00, lp_vec[d*CW +: CW]};
            if (d > 0) begin
                cand = {2'b00, lp_vec[((d > 0) ? d - 1 : 0)*CW +: CW]} + {2'b00, a_p1};
                if (cand < best) best = cand;
            end
            if (d < DISP - 1) begin
                cand = {2'b00, lp_vec[((d < DISP - 1) ? d + 1 : d)*CW +: CW]} + {2'b00, a_p1};
                if (cand < best) best = cand;
            end
            cand = {2'b00, mp} + {2'b00, a_p2};
            if (cand < best) best = cand;
            sum = {2'b00, a_cost[d*CW +: CW]} + best - {2'b00, mp};
            l_vec[d*CW +: CW] = (sum > SAT) ? SAT[CW-1:0] : sum[CW-1:0];
        end
        if (path_start) l_vec = a_cost;
    end

    sgm_path_aggr_min_tree #(.N(DISP), .W(CW)) u_min_out (
        .vals    (l_vec),
        .min_val (l_min)
    );

    // Stage B output register; also serves as the horizontal predecessor, so it holds across gaps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            cost_aggr <= '0;
            cost_min  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            valid <= a_en;
            if (a_en) begin
                cost_aggr <= l_vec;
                cost_min  <= l_min;
                out_row   <= a_row;
                out_col   <= a_col;
            end
        end
    end

endmodule

// File: tb/tb_sgm_path_aggr.sv
// Bench for sgm_path_aggr: directed scenarios plus random frames, scored against an integer reference model.
module tb_sgm_path_aggr;

    localparam int DISP    = 16;
    localparam int CW      = 9;
    localparam int MAX_COL = 4;
    localparam int RC_W    = 10;
    localparam int VW      = DISP * CW;
    localparam int SATV    = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              dir;
    logic [CW-1:0]     p1;
    logic [CW-1:0]     p2;
    logic [VW-1:0]     cost_init;
    logic [RC_W-1:0]   row;
    logic [RC_W-1:0]   col;
    logic [VW-1:0]     cost_aggr;
    logic [CW-1:0]     cost_min;
    logic [RC_W-1:0]   out_row;
    logic [RC_W-1:0]   out_col;
    logic              valid;

    always #5 clk = ~clk;

    sgm_path_aggr #(.DISP(DISP), .CW(CW), .MAX_COL(MAX_COL), .RC_W(RC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .p1        (p1),
        .p2        (p2),
        .cost_init (cost_init),
        .row       (row),
        .col       (col),
        .cost_aggr (cost_aggr),
        .cost_min  (cost_min),
        .out_row   (out_row),
        .out_col   (out_col),
        .valid     (valid)
    );

    typedef struct {
        bit              v;
        logic [VW-1:0]   aggr;
        logic [CW-1:0]   mn;
        logic [RC_W-1:0] r;
        logic [RC_W-1:0] c;
    } exp_t;

    exp_t hist1, hist2;
    int   checks   = 0;
    int   failures = 0;
    int   cvec [DISP];
    int   prev_h [DISP];
    int   vbuf [MAX_COL][DISP];
    bit   mode_m;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [VW-1:0] pack_all(input int v);
        logic [VW-1:0] p;
        p = '0;
        for (int d = 0; d < DISP; d++) p[d*CW +: CW] = CW'(v);
        return p;
    endfunction

    // Reference: L(p,d) from the path recurrence using plain integers
    task automatic model_pixel(input int r, input int c, input bit d_in, input int pp1, input int pp2,
                               output exp_t e);
        int lp [DISP];
        int l [DISP];
        int mp, pe, best, mn;
        bit start;
        if (r == 0 && c == 0) mode_m = d_in;
        for (int d = 0; d < DISP; d++) lp[d] = mode_m ? vbuf[c][d] : prev_h[d];
        start = mode_m ? (r == 0) : (c == 0);
        mp = lp[0];
        for (int d = 1; d < DISP; d++) if (lp[d] < mp) mp = lp[d];
        pe = (pp1 > pp2) ? pp1 : pp2;
        for (int d = 0; d < DISP; d++) begin
            if (start) begin
                l[d] = cvec[d];
            end else begin
                best = lp[d];
                if (d > 0 && lp[d-1] + pp1 < best) best = lp[d-1] + pp1;
                if (d < DISP - 1 && lp[d+1] + pp1 < best) best = lp[d+1] + pp1;
                if (mp + pe < best) best = mp + pe;
                l[d] = cvec[d] + best - mp;
                if (l[d] > SATV) l[d] = SATV;
            end
        end
        mn = l[0];
        for (int d = 1; d < DISP; d++) if (l[d] < mn) mn = l[d];
        e.v = 1'b1;
        e.aggr = '0;
        for (int d = 0; d < DISP; d++) begin
            e.aggr[d*CW +: CW] = CW'(l[d]);
            prev_h[d] = l[d];
            vbuf[c][d] = l[d];
        end
        e.mn = CW'(mn);
        e.r = RC_W'(r);
        e.c = RC_W'(c);
    endtask

    task automatic check_out(input exp_t e);
        checks++;
        assert (valid === e.v) else begin
            failures++;
            $error("FAIL valid got=%0b exp=%0b", valid, e.v);
        end
        if (e.v) begin
            chk($sformatf("aggr r%0d c%0d", e.r, e.c), cost_aggr, e.aggr);
            chk($sformatf("cost_min r%0d c%0d", e.r, e.c), VW'(cost_min), VW'(e.mn));
            chk("out_row", VW'(out_row), VW'(e.r));
            chk("out_col", VW'(out_col), VW'(e.c));
        end
    endtask

    // One clock of stimulus; called at the falling edge
    task automatic step(input bit e_in, input bit d_in, input int r, input int c);
        exp_t e;
        check_out(hist2);
        e.v = 1'b0;
        e.aggr = '0;
        e.mn = '0;
        e.r = '0;
        e.c = '0;
        if (e_in) model_pixel(r, c, d_in, int'(p1), int'(p2), e);
        hist2 = hist1;
        hist1 = e;
        en  = e_in;
        dir = d_in;
        row = RC_W'(r);
        col = RC_W'(c);
        for (int d = 0; d < DISP; d++) cost_init[d*CW +: CW] = CW'(cvec[d]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " valid"}, VW'(valid), '0);
        chk({tag, " aggr"}, cost_aggr, '0);
        chk({tag, " cost_min"}, VW'(cost_min), '0);
        chk({tag, " out_row"}, VW'(out_row), '0);
        chk({tag, " out_col"}, VW'(out_col), '0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        check_zero({tag, " in"});
        @(posedge clk);
        @(negedge clk);
        check_zero({tag, " hold"});
        en = 1'b0;
        rst = 1'b0;
        hist1.v = 1'b0;
        hist2.v = 1'b0;
        mode_m = 1'b0;
        for (int d = 0; d < DISP; d++) prev_h[d] = 0;
    endtask

    task automatic set_all(input int v);
        for (int d = 0; d < DISP; d++) cvec[d] = v;
    endtask

    task automatic set_rand(input int hi);
        for (int d = 0; d < DISP; d++) cvec[d] = int'($urandom_range(0, hi));
    endtask

    task automatic rand_frame(input int rows);
        bit fdir;
        fdir = 1'($urandom_range(0, 1));
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < MAX_COL; c++) begin
                set_rand((c % 2 == 0) ? 60 : SATV);
                step(1'b1, (r == 0 && c == 0) ? fdir : 1'($urandom_range(0, 1)), r, c);
                if ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom_range(0, 1)), 0, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; dir = 1'b0; p1 = '0; p2 = '0;
        cost_init = '0; row = '0; col = '0;
        hist1.v = 1'b0; hist2.v = 1'b0;
        hist1.aggr = '0; hist1.mn = '0; hist1.r = '0; hist1.c = '0;
        hist2 = hist1;
        for (int c = 0; c < MAX_COL; c++) for (int d = 0; d < DISP; d++) vbuf[c][d] = 0;
        @(negedge clk);
        apply_reset("reset");

        // T1: horizontal path start, uniform costs
        p1 = 2; p2 = 8;
        set_all(10);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 0, c);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        chk("t1 held aggr", cost_aggr, pack_all(10));
        chk("t1 cost_min", VW'(cost_min), VW'(10));

        // T2: single-disparity dip spreads by P1 to neighbours, P2 elsewhere
        p1 = 3; p2 = 20;
        set_all(50); cvec[5] = 0;
        step(1'b1, 1'b0, 0, 0);
        set_all(0);
        step(1'b1, 1'b0, 0, 1);
        step(1'b0, 1'b0, 0, 0);
        chk("t2 L5", VW'(cost_aggr[5*CW +: CW]), VW'(0));
        chk("t2 L4", VW'(cost_aggr[4*CW +: CW]), VW'(3));
        chk("t2 L6", VW'(cost_aggr[6*CW +: CW]), VW'(3));
        chk("t2 L0", VW'(cost_aggr[0 +: CW]), VW'(20));
        step(1'b0, 1'b0, 0, 0);

        // T3: dir pulse mid-frame ignored, then a vertical frame with gaps
        p1 = 5; p2 = 30;
        for (int c = 0; c < MAX_COL; c++) begin
            set_all(0);
            step(1'b1, (c == 2), 0, c);
            step(1'b0, 1'b1, 0, 0);
        end
        for (int c = 0; c < MAX_COL; c++) begin
            set_rand(40);
            step(1'b1, 1'b1, 1, c);
            step(1'b0, 1'b1, 0, 0);
        end
        for (int c = 0; c < MAX_COL; c++) begin
            set_all(0);
            step(1'b1, 1'b1, 0, c);
            step(1'b0, 1'b0, 0, 0);
        end
        for (int c = 0; c < MAX_COL; c++) begin
            set_all(1);
            step(1'b1, 1'b0, 1, c);
            step(1'b0, 1'b0, 0, 0);
            chk($sformatf("t3 vert c%0d", c), cost_aggr, pack_all(1));
        end

        // T4: saturation
        p1 = 9'd511; p2 = 9'd511;
        set_all(SATV); cvec[3] = 0;
        step(1'b1, 1'b0, 0, 0);
        set_all(SATV);
        step(1'b1, 1'b0, 0, 1);
        step(1'b0, 1'b0, 0, 0);
        chk("t4 sat", cost_aggr, pack_all(SATV));
        step(1'b0, 1'b0, 0, 0);

        // T5: p2 below p1 behaves as p2 = p1
        p1 = 10; p2 = 4;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < MAX_COL; c++) begin
                set_rand(40);
                step(1'b1, 1'b0, r, c);
            end
        p1 = 10; p2 = 4;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < MAX_COL; c++) begin
                set_rand(40);
                step(1'b1, (r == 0 && c == 0), r, c);
            end
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);

        // T6: reset in the middle of a frame, then a fresh frame
        p1 = 7; p2 = 25;
        for (int c = 0; c < MAX_COL; c++) begin
            set_rand(100);
            step(1'b1, 1'b0, 0, c);
        end
        for (int c = 0; c < 2; c++) begin
            set_rand(100);
            step(1'b1, 1'b0, 1, c);
        end
        set_rand(100);
        en = 1'b1; row = 1; col = 2;
        apply_reset("t6 reset");
        check_out(hist2);
        rand_frame(3);

        // Random frames with random penalties, directions and gaps
        for (int f = 0; f < 12; f++) begin
            p1 = CW'($urandom_range(0, 40));
            p2 = CW'($urandom_range(0, 120));
            rand_frame(3);
        end
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
